calculator_seq: RTL and testbench

// - Parametrised successor of the board's hex calculator: button-driven ALU with result chaining
//   (add, sub, mul, div, mod, square), sitting between switch/button inputs and the 7-seg display driver.
// - Adds multi-cycle division, busy/done handshake, error code, and an explicit clear.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_div_seq.sv | 74 +++++++
 rtl/calculator_seq.sv | 185 ++++++++++++++++++
 tb/tb_calculator_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator: op codes, error codes, FSM states.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_SQR = 3'b101;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_DIV0  = 2'b01;
  localparam logic [1:0] ERR_ILLOP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DIV   = 2'd3
  } state_t;

endpackage

// File: rtl/calc_div_seq.sv
// Restoring divider, one quotient bit per clock. The start cycle already performs
// the first iteration, so valid pulses W clocks after start.
module calc_div_seq #(
  parameter int W = 32
) (
  input  logic         clk_g,
  input  logic         rst,
  input  logic         abort,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_reg, quo_reg, dsr_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg, valid_reg;

  logic [W-1:0]  in_rem, in_quo, in_dsr;
  logic [W:0]    shifted, trial;
  logic [W-1:0]  rem_next, quo_next;

  // One restoring step; on start it works on the fresh operands instead of the registers.
  always_comb begin
    in_rem   = start ? '0 : rem_reg;
    in_quo   = start ? dividend : quo_reg;
    in_dsr   = start ? divisor : dsr_reg;
    shifted  = {in_rem, in_quo[W-1]};
    trial    = shifted - {1'b0, in_dsr};
    // Borrow out of the top bit means the trial subtraction went negative: restore.
    rem_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    quo_next = {in_quo[W-2:0], ~trial[W]};
  end

  // Iteration counter and datapath registers; abort behaves like a local reset.
  always_ff @(posedge clk_g) begin
    if (rst || abort) begin
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (start) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        dsr_reg  <= divisor;
        cnt_reg  <= CW'(W - 1);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          busy_reg  <= 1'b0;
          valid_reg <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign valid     = valid_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/calculator_seq.sv
// Button-driven calculator with result chaining, sticky error and multi-cycle divide.
module calculator_seq
  import calc_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RES_W = 32
) (
  input  logic             clk_g,
  input  logic             rst,
  input  logic             clr,
  input  logic             button,
  input  logic [IN_W-1:0]  num1,
  input  logic [IN_W-1:0]  num2,
  input  logic [2:0]       func,
  output logic             busy,
  output logic             done,
  output logic             chain,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [RES_W-1:0] cal_result
);

  state_t            state_reg, state_next;
  logic              btn_q_reg;
  logic [RES_W-1:0]  op_a_reg, op_a_next, op_b_reg, op_b_next;
  logic [2:0]        func_reg, func_next;
  logic [RES_W-1:0]  cal_result_reg, cal_result_next;
  logic              chain_reg, chain_next, error_reg, error_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic              done_reg, done_next, busy_reg, busy_next;
  logic              rise, fall, div_start, div_busy, div_valid;
  logic [RES_W-1:0]  div_quo, div_rem, alu_res;

  assign rise = button & ~btn_q_reg;
  assign fall = ~button & btn_q_reg;

  calc_div_seq #(.W(RES_W)) u_div (
    .clk_g     (clk_g),
    .rst       (rst),
    .abort     (clr),
    .start     (div_start),
    .dividend  (op_a_reg),
    .divisor   (op_b_reg),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Single-cycle ALU; products are truncated to RES_W by the assignment width.
  always_comb begin
    alu_res = '0;
    case (func_reg)
      OP_ADD:  alu_res = op_a_reg + op_b_reg;
      OP_SUB:  alu_res = op_a_reg - op_b_reg;
      OP_MUL:  alu_res = op_a_reg * op_b_reg;
      OP_SQR:  alu_res = op_a_reg * op_a_reg;
      default: alu_res = '0;
    endcase
  end

  // Next-state and register updates; clr overrides any button activity.
  always_comb begin
    state_next      = state_reg;
    op_a_next       = op_a_reg;
    op_b_next       = op_b_reg;
    func_next       = func_reg;
    cal_result_next = cal_result_reg;
    chain_next      = chain_reg;
    error_next      = error_reg;
    err_code_next   = err_code_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    div_start       = 1'b0;
    if (clr) begin
      state_next      = ST_IDLE;
      op_a_next       = '0;
      op_b_next       = '0;
      func_next       = '0;
      cal_result_next = '0;
      chain_next      = 1'b0;
      error_next      = 1'b0;
      err_code_next   = ERR_NONE;
      busy_next       = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rise && !error_reg) begin
            op_a_next  = chain_reg ? cal_result_reg : RES_W'(num1);
            op_b_next  = RES_W'(num2);
            state_next = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (fall) begin
            func_next  = func;
            busy_next  = 1'b1;
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (func_reg)
            OP_ADD, OP_SUB, OP_MUL, OP_SQR: begin
              cal_result_next = alu_res;
              chain_next      = 1'b1;
              done_next       = 1'b1;
              busy_next       = 1'b0;
              state_next      = ST_IDLE;
            end
            OP_DIV, OP_MOD: begin
              if (op_b_reg == '0) begin
                error_next    = 1'b1;
                err_code_next = ERR_DIV0;
                done_next     = 1'b1;
                busy_next     = 1'b0;
                state_next    = ST_IDLE;
              end else begin
                div_start  = 1'b1;
                state_next = ST_DIV;
              end
            end
            default: begin
              error_next    = 1'b1;
              err_code_next = ERR_ILLOP;
              done_next     = 1'b1;
              busy_next     = 1'b0;
              state_next    = ST_IDLE;
            end
          endcase
        end
        ST_DIV: begin
          if (div_valid) begin
            cal_result_next = (func_reg == OP_MOD) ? div_rem : div_quo;
            chain_next      = 1'b1;
            done_next       = 1'b1;
            busy_next       = 1'b0;
            state_next      = ST_IDLE;
          end else if (!div_busy) begin
            // Divider idle without a result: recover rather than hang in DIV.
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_g) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      btn_q_reg      <= 1'b0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      func_reg       <= '0;
      cal_result_reg <= '0;
      chain_reg      <= 1'b0;
      error_reg      <= 1'b0;
      err_code_reg   <= ERR_NONE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      btn_q_reg      <= button;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      func_reg       <= func_next;
      cal_result_reg <= cal_result_next;
      chain_reg      <= chain_next;
      error_reg      <= error_next;
      err_code_reg   <= err_code_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign chain      = chain_reg;
  assign error      = error_reg;
  assign err_code   = err_code_reg;
  assign cal_result = cal_result_reg;

endmodule

// File: tb/tb_calculator_seq.sv
// Scoreboard bench for calculator_seq: stimulus pushes expected results, a monitor
// pops one entry per done pulse.
module tb_calculator_seq;

  logic        clk_g = 1'b0;
  logic        rst, clr, button;
  logic [7:0]  num1, num2;
  logic [2:0]  func;
  logic        busy, done, chain, error;
  logic [1:0]  err_code;
  logic [31:0] cal_result;

  typedef struct packed {
    logic [31:0] res;
    logic        chain;
    logic        error;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  int   bc;

  calculator_seq #(.IN_W(8), .RES_W(32)) dut (
    .clk_g      (clk_g),
    .rst        (rst),
    .clr        (clr),
    .button     (button),
    .num1       (num1),
    .num2       (num2),
    .func       (func),
    .busy       (busy),
    .done       (done),
    .chain      (chain),
    .error      (error),
    .err_code   (err_code),
    .cal_result (cal_result)
  );

  always #5 clk_g = ~clk_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_g) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual result=%h error=%b expected no done", cal_result, error);
      end else begin
        e = exp_q.pop_front();
        txn++;
        if ({cal_result, chain, error, err_code} !== e) begin
          errors++;
          $display("FAIL txn%0d actual res=%h chain=%b err=%b code=%b expected res=%h chain=%b err=%b code=%b",
                   txn, cal_result, chain, error, err_code, e.res, e.chain, e.error, e.code);
        end else begin
          $display("txn %0d result=%h chain=%b error=%b err_code=%b ok",
                   txn, cal_result, chain, error, err_code);
        end
      end
    end
  end

  task automatic expect_result(input logic [31:0] r, input logic ch, input logic er, input logic [1:0] cd);
    exp_q.push_back({r, ch, er, cd});
  endtask

  // Press and release, scrambling operands during the hold; returns busy cycle count.
  task automatic press(input logic [7:0] n1, input logic [7:0] n2, input logic [2:0] f,
                       output int busy_cycles);
    @(negedge clk_g);
    num1 = n1; num2 = n2; func = f; button = 1'b1;
    @(negedge clk_g);
    num1 = ~n1; num2 = ~n2; button = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_g);
      if (busy) busy_cycles++;
      else break;
    end
  endtask

  task automatic start_op(input logic [7:0] n1, input logic [7:0] n2, input logic [2:0] f);
    @(negedge clk_g);
    num1 = n1; num2 = n2; func = f; button = 1'b1;
    @(negedge clk_g);
    button = 1'b0;
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk_g);
    clr = 1'b1;
    @(negedge clk_g);
    clr = 1'b0;
    chk({tag, "_result"}, cal_result, 32'h0);
    chk({tag, "_chain"}, {31'b0, chain}, 32'h0);
    chk({tag, "_error"}, {31'b0, error}, 32'h0);
    chk({tag, "_errcode"}, {30'b0, err_code}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; button = 1'b0; num1 = '0; num2 = '0; func = '0;
    repeat (3) @(negedge clk_g);
    chk("reset_result", cal_result, 32'h0);
    chk("reset_busy_done", {30'b0, busy, done}, 32'h0);
    chk("reset_flags", {28'b0, chain, error, err_code}, 32'h0);
    rst = 1'b0;

    // Add, then chained subtract (num1 ignored)
    expect_result(32'h0000_0046, 1'b1, 1'b0, 2'b00);
    press(8'h12, 8'h34, 3'b000, bc);
    chk("add_busy_cycles", bc, 32'd1);
    expect_result(32'h0000_0040, 1'b1, 1'b0, 2'b00);
    press(8'h99, 8'h06, 3'b001, bc);

    // Subtract wrap
    do_clr("clr1");
    expect_result(32'hFFFF_FFFF, 1'b1, 1'b0, 2'b00);
    press(8'h00, 8'h01, 3'b001, bc);

    // Divide and chained modulo
    do_clr("clr2");
    expect_result(32'h0000_000F, 1'b1, 1'b0, 2'b00);
    press(8'hFF, 8'h10, 3'b011, bc);
    chk("div_busy_cycles", bc, 32'd33);
    expect_result(32'h0000_0003, 1'b1, 1'b0, 2'b00);
    press(8'h55, 8'h04, 3'b100, bc);
    chk("mod_busy_cycles", bc, 32'd33);

    // Divide by zero: sticky error, result and chain held
    expect_result(32'h0000_0003, 1'b1, 1'b1, 2'b01);
    press(8'h07, 8'h00, 3'b011, bc);
    chk("div0_busy_cycles", bc, 32'd1);
    press(8'h01, 8'h02, 3'b000, bc);
    chk("ignored_busy", bc, 32'd0);
    chk("ignored_result", cal_result, 32'h0000_0003);
    chk("ignored_flags", {28'b0, chain, error, err_code}, 32'b1101);
    do_clr("clr3");

    // Illegal op, then square and chained multiply
    expect_result(32'h0, 1'b0, 1'b1, 2'b10);
    press(8'h05, 8'h03, 3'b111, bc);
    do_clr("clr4");
    expect_result(32'h0000_FE01, 1'b1, 1'b0, 2'b00);
    press(8'hFF, 8'h00, 3'b101, bc);
    expect_result(32'h0001_FC02, 1'b1, 1'b0, 2'b00);
    press(8'h00, 8'h02, 3'b010, bc);

    // clr together with a rise: the press is discarded
    do_clr("clr5");
    @(negedge clk_g);
    clr = 1'b1; button = 1'b1; num1 = 8'h33; num2 = 8'h44; func = 3'b000;
    @(negedge clk_g);
    clr = 1'b0;
    @(negedge clk_g);
    button = 1'b0;
    repeat (3) @(negedge clk_g);
    chk("clr_rise_busy", {31'b0, busy}, 32'h0);
    expect_result(32'h0000_0011, 1'b1, 1'b0, 2'b00);
    press(8'h10, 8'h01, 3'b000, bc);

    // clr aborts a running divide
    start_op(8'h00, 8'h03, 3'b011);
    repeat (10) @(negedge clk_g);
    chk("abort_busy_before", {31'b0, busy}, 32'h1);
    clr = 1'b1;
    @(negedge clk_g);
    clr = 1'b0;
    chk("abort_busy_after", {31'b0, busy}, 32'h0);
    chk("abort_result", cal_result, 32'h0);
    chk("abort_chain", {31'b0, chain}, 32'h0);
    repeat (40) @(negedge clk_g);
    chk("abort_still_idle", {31'b0, busy}, 32'h0);

    // rst aborts a running divide
    expect_result(32'h0000_0046, 1'b1, 1'b0, 2'b00);
    press(8'h12, 8'h34, 3'b000, bc);
    start_op(8'h00, 8'h05, 3'b011);
    repeat (10) @(negedge clk_g);
    rst = 1'b1;
    @(negedge clk_g);
    rst = 1'b0;
    chk("rst_busy_after", {31'b0, busy}, 32'h0);
    chk("rst_result", cal_result, 32'h0);
    chk("rst_chain", {31'b0, chain}, 32'h0);
    repeat (40) @(negedge clk_g);
    chk("rst_still_idle", {31'b0, busy}, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
